// File: rtl/multdiv_ctrl_if.sv
// Execute-stage <-> HI/LO sequencer bundle. The slave side is the sequencer.
// The master side is the surrounding execute stage, multiplier and divider.
interface multdiv_ctrl_if;
  logic        req_valid;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi_in;
  logic [31:0] lo_in;
  logic        flush;
  logic        stall_in;
  logic        mul_start;
  logic        mul_signed;
  logic [63:0] mul_prod;
  logic        div_start;
  logic        div_signed;
  logic        div_abort;
  logic        div_done;
  logic [31:0] div_q;
  logic [31:0] div_r;
  logic        ok;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic [31:0] gpr_res;
  logic        busy;

  modport slave (
    input  req_valid, op, a, b, hi_in, lo_in, flush, stall_in,
           mul_prod, div_done, div_q, div_r,
    output mul_start, mul_signed, div_start, div_signed, div_abort,
           ok, hi_we, lo_we, res_hi, res_lo, gpr_res, busy
  );

  modport master (
    output req_valid, op, a, b, hi_in, lo_in, flush, stall_in,
           mul_prod, div_done, div_q, div_r,
    input  mul_start, mul_signed, div_start, div_signed, div_abort,
           ok, hi_we, lo_we, res_hi, res_lo, gpr_res, busy
  );
endinterface

// File: rtl/multdiv_ctrl.sv
// HI/LO multicycle sequencer: launches the external multiplier/divider,
// applies accumulate and divide-by-zero rules, holds the result under stall.
module multdiv_ctrl #(
  parameter int MUL_LATENCY = 3
) (
  input logic          clk,
  input logic          reset,
  multdiv_ctrl_if.slave bus
);
  localparam int CW = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MUL_LATENCY - 1);

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MADD  = 4'd5;
  localparam logic [3:0] OP_MADDU = 4'd6;
  localparam logic [3:0] OP_MSUB  = 4'd7;
  localparam logic [3:0] OP_MSUBU = 4'd8;
  localparam logic [3:0] OP_MUL   = 4'd9;
  localparam logic [3:0] OP_MTHI  = 4'd10;
  localparam logic [3:0] OP_MTLO  = 4'd11;

  typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]  op_q;
  logic [31:0] res_hi_q, res_lo_q, gpr_q;
  logic        hi_we_q, lo_we_q;

  logic is_mul, is_div, mul_sgn, op_none;
  logic mul_start_c, div_start_c, div_abort_c, sgn_c;
  logic ld_req, ld_mul, ld_div, ld_dz, ld_mthi, ld_mtlo;
  logic [63:0] acc, acc_add, acc_sub;

  // Decode the op currently presented by execute.
  always_comb begin
    is_mul  = (bus.op == OP_MULT) || (bus.op == OP_MULTU) || (bus.op == OP_MADD) ||
              (bus.op == OP_MADDU) || (bus.op == OP_MSUB) || (bus.op == OP_MSUBU) ||
              (bus.op == OP_MUL);
    is_div  = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
    mul_sgn = (bus.op == OP_MULT) || (bus.op == OP_MADD) ||
              (bus.op == OP_MSUB) || (bus.op == OP_MUL);
    op_none = (bus.op == OP_NONE) || (bus.op > OP_MTLO);
  end

  // Next state, unit launch pulses and result-load strobes; flush wins over all.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mul_start_c = 1'b0;
    div_start_c = 1'b0;
    div_abort_c = 1'b0;
    sgn_c       = 1'b0;
    ld_req      = 1'b0;
    ld_mul      = 1'b0;
    ld_div      = 1'b0;
    ld_dz       = 1'b0;
    ld_mthi     = 1'b0;
    ld_mtlo     = 1'b0;
    if (bus.flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      // The divider must be told to drop either a running or a would-be launch.
      if (state_q == DIV_WAIT ||
          (state_q == IDLE && bus.req_valid && is_div && bus.b != 32'd0))
        div_abort_c = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: if (bus.req_valid) begin
          if (is_mul) begin
            mul_start_c = 1'b1;
            sgn_c       = mul_sgn;
            ld_req      = 1'b1;
            cnt_d       = '0;
            state_d     = MUL_WAIT;
          end else if (is_div) begin
            if (bus.b != 32'd0) begin
              div_start_c = 1'b1;
              sgn_c       = (bus.op == OP_DIV);
              ld_req      = 1'b1;
              state_d     = DIV_WAIT;
            end else begin
              ld_dz   = 1'b1;
              state_d = DONE;
            end
          end else if (bus.op == OP_MTHI) begin
            ld_mthi = 1'b1;
            state_d = DONE;
          end else if (bus.op == OP_MTLO) begin
            ld_mtlo = 1'b1;
            state_d = DONE;
          end
        end
        MUL_WAIT: begin
          if (cnt_q == CNT_LAST) begin
            ld_mul  = 1'b1;
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        DIV_WAIT: if (bus.div_done) begin
          ld_div  = 1'b1;
          state_d = DONE;
        end
        DONE: if (!bus.stall_in) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM state and latency counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Accumulate uses HI/LO as they stand at latch time.
  always_comb begin
    acc     = {bus.hi_in, bus.lo_in};
    acc_add = acc + bus.mul_prod;
    acc_sub = acc - bus.mul_prod;
  end

  // Result registers: written once per op, then held until the next op.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= OP_NONE;
      res_hi_q <= '0;
      res_lo_q <= '0;
      gpr_q    <= '0;
      hi_we_q  <= 1'b0;
      lo_we_q  <= 1'b0;
    end else begin
      if (ld_req) op_q <= bus.op;
      if (ld_mul) begin
        unique case (op_q)
          OP_MADD, OP_MADDU: begin
            {res_hi_q, res_lo_q} <= acc_add;
            hi_we_q <= 1'b1;
            lo_we_q <= 1'b1;
          end
          OP_MSUB, OP_MSUBU: begin
            {res_hi_q, res_lo_q} <= acc_sub;
            hi_we_q <= 1'b1;
            lo_we_q <= 1'b1;
          end
          OP_MUL: begin
            gpr_q   <= bus.mul_prod[31:0];
            hi_we_q <= 1'b0;
            lo_we_q <= 1'b0;
          end
          default: begin
            {res_hi_q, res_lo_q} <= bus.mul_prod;
            hi_we_q <= 1'b1;
            lo_we_q <= 1'b1;
          end
        endcase
      end
      if (ld_div) begin
        res_lo_q <= bus.div_q;
        res_hi_q <= bus.div_r;
        hi_we_q  <= 1'b1;
        lo_we_q  <= 1'b1;
      end
      if (ld_dz) begin
        res_hi_q <= bus.a;
        res_lo_q <= 32'hFFFF_FFFF;
        hi_we_q  <= 1'b1;
        lo_we_q  <= 1'b1;
      end
      if (ld_mthi) begin
        res_hi_q <= bus.a;
        hi_we_q  <= 1'b1;
        lo_we_q  <= 1'b0;
      end
      if (ld_mtlo) begin
        res_lo_q <= bus.a;
        hi_we_q  <= 1'b0;
        lo_we_q  <= 1'b1;
      end
    end
  end

  // Pulses are masked during reset; the divider is reset alongside us, so no abort.
  assign bus.mul_start  = mul_start_c & ~reset;
  assign bus.div_start  = div_start_c & ~reset;
  assign bus.div_abort  = div_abort_c & ~reset;
  assign bus.mul_signed = sgn_c & mul_start_c;
  assign bus.div_signed = sgn_c & div_start_c;
  assign bus.ok         = ~reset & ((state_q == DONE) ||
                                    (state_q == IDLE && (!bus.req_valid || op_none)));
  assign bus.hi_we      = (state_q == DONE) & hi_we_q;
  assign bus.lo_we      = (state_q == DONE) & lo_we_q;
  assign bus.res_hi     = res_hi_q;
  assign bus.res_lo     = res_lo_q;
  assign bus.gpr_res    = gpr_q;
  assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl. Inputs change on the falling edge and outputs
// are sampled 1 time unit later, so every sample sits mid-cycle.
module tb_multdiv_ctrl;
  localparam int L = 3;
  localparam logic [3:0] NONE = 4'd0, MULT = 4'd1, DIV = 4'd3, DIVU = 4'd4,
                         MADDU = 4'd6, MSUB = 4'd7, MUL = 4'd9, MTLO = 4'd11;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  multdiv_ctrl_if bus ();
  multdiv_ctrl #(.MUL_LATENCY(L)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // Fixed-latency multiplier model; outside its valid slot it presents junk.
  logic signed [63:0] sa, sb;
  logic [63:0] prod_now;
  logic [63:0] mp [1:L];
  always_comb begin
    sa = bus.mul_signed ? {{32{bus.a[31]}}, bus.a} : {32'd0, bus.a};
    sb = bus.mul_signed ? {{32{bus.b[31]}}, bus.b} : {32'd0, bus.b};
    prod_now = sa * sb;
  end
  always @(posedge clk) begin
    mp[1] <= bus.mul_start ? prod_now : 64'hBAD0_BAD0_BAD0_BAD0;
    for (int i = 2; i <= L; i++) mp[i] <= mp[i-1];
  end
  assign bus.mul_prod = mp[L];

  task automatic test_reset();
    reset = 1'b1; bus.req_valid = 1'b1; bus.op = MULT; bus.a = 32'd2; bus.b = 32'd3;
    @(negedge clk); @(negedge clk); #1;
    checks++; if (bus.ok !== 1'b0) begin errors++; $display("FAIL rst_ok got=%b exp=0", bus.ok); end
    checks++; if (bus.mul_start !== 1'b0) begin errors++; $display("FAIL rst_mul_start got=%b exp=0", bus.mul_start); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    checks++; if ({bus.res_hi, bus.res_lo, bus.gpr_res} !== 96'd0) begin errors++;
      $display("FAIL rst_results got=%h_%h_%h exp=0", bus.res_hi, bus.res_lo, bus.gpr_res); end
    checks++; if ({bus.hi_we, bus.lo_we} !== 2'b00) begin errors++; $display("FAIL rst_we got=%b%b exp=00", bus.hi_we, bus.lo_we); end
    reset = 1'b0; bus.req_valid = 1'b0; #1;
    checks++; if (bus.ok !== 1'b1) begin errors++; $display("FAIL idle_ok got=%b exp=1", bus.ok); end
    // Reset while a divide is in flight: back to IDLE, no abort pulse.
    @(negedge clk); bus.req_valid = 1'b1; bus.op = DIVU; bus.a = 32'd10; bus.b = 32'd3; #1;
    checks++; if (bus.div_start !== 1'b1) begin errors++; $display("FAIL rstmid_div_start got=%b exp=1", bus.div_start); end
    @(negedge clk); reset = 1'b1; #1;
    checks++; if ({bus.busy, bus.div_abort} !== 2'b10) begin errors++;
      $display("FAIL rstmid_abort busy/abort got=%b%b exp=10", bus.busy, bus.div_abort); end
    @(negedge clk); #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle got=%b exp=0", bus.busy); end
    reset = 1'b0; bus.req_valid = 1'b0;
  endtask

  task automatic test_none();
    @(negedge clk); bus.req_valid = 1'b1; bus.op = 4'd12; #1;
    checks++; if ({bus.ok, bus.mul_start, bus.div_start} !== 3'b100) begin errors++;
      $display("FAIL none_op ok/ms/ds got=%b%b%b exp=100", bus.ok, bus.mul_start, bus.div_start); end
    @(negedge clk); #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL none_busy got=%b exp=0", bus.busy); end
    bus.req_valid = 1'b0;
  endtask

  task automatic test_mult();
    int early_ok = 0;
    @(negedge clk); bus.req_valid = 1'b1; bus.op = MULT; bus.a = 32'hFFFF_FFFE; bus.b = 32'd3; #1;
    checks++; if ({bus.mul_start, bus.mul_signed, bus.ok} !== 3'b110) begin errors++;
      $display("FAIL mult_t0 start/sgn/ok got=%b%b%b exp=110", bus.mul_start, bus.mul_signed, bus.ok); end
    for (int i = 1; i <= L; i++) begin
      @(negedge clk); #1;
      if (bus.ok !== 1'b0 || bus.mul_start !== 1'b0) early_ok++;
    end
    checks++; if (early_ok !== 0) begin errors++; $display("FAIL mult_wait bad_cycles got=%0d exp=0", early_ok); end
    @(negedge clk); #1;
    checks++; if (bus.ok !== 1'b1) begin errors++; $display("FAIL mult_ok_t4 got=%b exp=1", bus.ok); end
    checks++; if ({bus.res_hi, bus.res_lo} !== 64'hFFFF_FFFF_FFFF_FFFA) begin errors++;
      $display("FAIL mult_res got=%h_%h exp=ffffffff_fffffffa", bus.res_hi, bus.res_lo); end
    checks++; if ({bus.hi_we, bus.lo_we} !== 2'b11) begin errors++; $display("FAIL mult_we got=%b%b exp=11", bus.hi_we, bus.lo_we); end
    bus.req_valid = 1'b0;
    @(negedge clk); #1;
    checks++; if ({bus.busy, bus.hi_we} !== 2'b00) begin errors++; $display("FAIL mult_exit busy/we got=%b%b exp=00", bus.busy, bus.hi_we); end
  endtask

  task automatic test_accumulate();
    // MADDU: {0,FFFFFFFF} + 1 carries into HI.
    @(negedge clk); bus.req_valid = 1'b1; bus.op = MADDU; bus.a = 32'd1; bus.b = 32'd1;
    bus.hi_in = 32'd0; bus.lo_in = 32'hFFFF_FFFF; #1;
    checks++; if ({bus.mul_start, bus.mul_signed} !== 2'b10) begin errors++;
      $display("FAIL maddu_start start/sgn got=%b%b exp=10", bus.mul_start, bus.mul_signed); end
    repeat (L + 1) @(negedge clk); #1;
    checks++; if ({bus.ok, bus.res_hi, bus.res_lo} !== {1'b1, 32'd1, 32'd0}) begin errors++;
      $display("FAIL maddu_res ok=%b got=%h_%h exp=00000001_00000000", bus.ok, bus.res_hi, bus.res_lo); end
    bus.req_valid = 1'b0;
    // MSUB: 0 - 1 wraps to all ones.
    @(negedge clk); bus.req_valid = 1'b1; bus.op = MSUB; bus.hi_in = 32'd0; bus.lo_in = 32'd0; #1;
    checks++; if ({bus.mul_start, bus.mul_signed} !== 2'b11) begin errors++;
      $display("FAIL msub_start start/sgn got=%b%b exp=11", bus.mul_start, bus.mul_signed); end
    repeat (L + 1) @(negedge clk); #1;
    checks++; if ({bus.ok, bus.res_hi, bus.res_lo} !== {1'b1, 64'hFFFF_FFFF_FFFF_FFFF}) begin errors++;
      $display("FAIL msub_res ok=%b got=%h_%h exp=ffffffff_ffffffff", bus.ok, bus.res_hi, bus.res_lo); end
    bus.req_valid = 1'b0;
  endtask

  task automatic test_divu();
    int bad = 0;
    bus.div_q = 32'hDEAD_BEEF; bus.div_r = 32'hDEAD_BEEF;
    @(negedge clk); bus.req_valid = 1'b1; bus.op = DIVU; bus.a = 32'd100; bus.b = 32'd7; #1;
    checks++; if ({bus.div_start, bus.div_signed, bus.mul_start} !== 3'b100) begin errors++;
      $display("FAIL divu_start start/sgn/ms got=%b%b%b exp=100", bus.div_start, bus.div_signed, bus.mul_start); end
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk); #1;
      if (bus.ok !== 1'b0 || bus.div_start !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL divu_wait bad_cycles got=%0d exp=0", bad); end
    @(negedge clk); bus.div_done = 1'b1; bus.div_q = 32'd14; bus.div_r = 32'd2; #1;
    checks++; if (bus.ok !== 1'b0) begin errors++; $display("FAIL divu_ok_t33 got=%b exp=0", bus.ok); end
    @(negedge clk); bus.div_done = 1'b0; bus.div_q = 32'hDEAD_BEEF; bus.div_r = 32'hDEAD_BEEF; #1;
    checks++; if ({bus.ok, bus.res_lo, bus.res_hi} !== {1'b1, 32'd14, 32'd2}) begin errors++;
      $display("FAIL divu_res ok=%b got lo=%0d hi=%0d exp lo=14 hi=2", bus.ok, bus.res_lo, bus.res_hi); end
    checks++; if ({bus.hi_we, bus.lo_we} !== 2'b11) begin errors++; $display("FAIL divu_we got=%b%b exp=11", bus.hi_we, bus.lo_we); end
    bus.req_valid = 1'b0;
  endtask

  task automatic test_div_zero();
    @(negedge clk); bus.req_valid = 1'b1; bus.op = DIV; bus.a = 32'd5; bus.b = 32'd0; #1;
    checks++; if ({bus.div_start, bus.ok} !== 2'b00) begin errors++;
      $display("FAIL dz_t0 start/ok got=%b%b exp=00", bus.div_start, bus.ok); end
    @(negedge clk); #1;
    checks++; if ({bus.ok, bus.res_hi, bus.res_lo, bus.hi_we, bus.lo_we} !== {1'b1, 32'd5, 32'hFFFF_FFFF, 2'b11}) begin errors++;
      $display("FAIL dz_res ok=%b hi=%h lo=%h we=%b%b exp ok=1 hi=5 lo=ffffffff we=11",
               bus.ok, bus.res_hi, bus.res_lo, bus.hi_we, bus.lo_we); end
    bus.req_valid = 1'b0;
  endtask

  task automatic test_flush();
    // Flush while waiting on a signed divide.
    @(negedge clk); bus.req_valid = 1'b1; bus.op = DIV; bus.a = 32'hFFFF_FFF9; bus.b = 32'd2; #1;
    checks++; if ({bus.div_start, bus.div_signed} !== 2'b11) begin errors++;
      $display("FAIL div_start start/sgn got=%b%b exp=11", bus.div_start, bus.div_signed); end
    @(negedge clk); @(negedge clk); bus.flush = 1'b1; #1;
    checks++; if ({bus.div_abort, bus.ok} !== 2'b10) begin errors++;
      $display("FAIL flush_abort abort/ok got=%b%b exp=10", bus.div_abort, bus.ok); end
    @(negedge clk); bus.flush = 1'b0; bus.req_valid = 1'b0;
    bus.div_done = 1'b1; bus.div_q = 32'd99; bus.div_r = 32'd99; #1;
    checks++; if ({bus.busy, bus.div_abort} !== 2'b00) begin errors++;
      $display("FAIL flush_idle busy/abort got=%b%b exp=00", bus.busy, bus.div_abort); end
    @(negedge clk); bus.div_done = 1'b0; #1;
    checks++; if ({bus.busy, bus.hi_we, bus.lo_we, bus.res_lo} !== {3'b000, 32'hFFFF_FFFF}) begin errors++;
      $display("FAIL late_done busy=%b we=%b%b lo=%h exp busy=0 we=00 lo=ffffffff",
               bus.busy, bus.hi_we, bus.lo_we, bus.res_lo); end
    // MTLO right after the flush.
    @(negedge clk); bus.req_valid = 1'b1; bus.op = MTLO; bus.a = 32'h1234; #1;
    checks++; if (bus.ok !== 1'b0) begin errors++; $display("FAIL mtlo_t0_ok got=%b exp=0", bus.ok); end
    @(negedge clk); #1;
    checks++; if ({bus.ok, bus.lo_we, bus.hi_we, bus.res_lo, bus.res_hi} !== {3'b110, 32'h1234, 32'd5}) begin errors++;
      $display("FAIL mtlo_res ok=%b we lo/hi=%b%b lo=%h hi=%h exp ok=1 we=10 lo=1234 hi=5",
               bus.ok, bus.lo_we, bus.hi_we, bus.res_lo, bus.res_hi); end
    bus.req_valid = 1'b0;
    // Flush on the very cycle a divide would launch.
    @(negedge clk); bus.req_valid = 1'b1; bus.op = DIVU; bus.b = 32'd3; bus.flush = 1'b1; #1;
    checks++; if ({bus.div_start, bus.div_abort} !== 2'b01) begin errors++;
      $display("FAIL flush_launch start/abort got=%b%b exp=01", bus.div_start, bus.div_abort); end
    @(negedge clk); bus.flush = 1'b0; bus.req_valid = 1'b0; #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_launch_idle got=%b exp=0", bus.busy); end
  endtask

  task automatic test_mul_stall();
    int restarts = 0, unstable = 0;
    @(negedge clk); bus.req_valid = 1'b1; bus.op = MUL; bus.a = 32'h0001_0001; bus.b = 32'h0001_0001; #1;
    checks++; if ({bus.mul_start, bus.mul_signed} !== 2'b11) begin errors++;
      $display("FAIL mul_start start/sgn got=%b%b exp=11", bus.mul_start, bus.mul_signed); end
    repeat (L + 1) @(negedge clk); bus.stall_in = 1'b1; #1;
    checks++; if ({bus.ok, bus.gpr_res, bus.hi_we, bus.lo_we} !== {1'b1, 32'h0002_0001, 2'b00}) begin errors++;
      $display("FAIL mul_res ok=%b gpr=%h we=%b%b exp ok=1 gpr=00020001 we=00",
               bus.ok, bus.gpr_res, bus.hi_we, bus.lo_we); end
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); if (i == 4) bus.stall_in = 1'b0; #1;
      if (bus.ok !== 1'b1 || bus.gpr_res !== 32'h0002_0001) unstable++;
      if (bus.mul_start !== 1'b0) restarts++;
    end
    checks++; if (unstable !== 0) begin errors++; $display("FAIL stall_hold bad_cycles got=%0d exp=0", unstable); end
    checks++; if (restarts !== 0) begin errors++; $display("FAIL stall_restart got=%0d exp=0", restarts); end
    bus.req_valid = 1'b0;
    @(negedge clk); #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL stall_exit busy got=%b exp=0", bus.busy); end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.op = NONE; bus.a = '0; bus.b = '0;
    bus.hi_in = '0; bus.lo_in = '0; bus.flush = 1'b0; bus.stall_in = 1'b0;
    bus.div_done = 1'b0; bus.div_q = '0; bus.div_r = '0;
    test_reset();
    test_none();
    test_mult();
    test_accumulate();
    test_divu();
    test_div_zero();
    test_flush();
    test_mul_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired after %0d checks", checks);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/multdiv_ctrl.md
Name: multdiv_ctrl

Overview:
- Sequences the HI/LO multicycle arithmetic used by the execute stage: MULT/MULTU/DIV/DIVU/MADD(U)/MSUB(U)/MUL/MTHI/MTLO.
- Issues start/abort to an external fixed-latency multiplier and an iterative divider, then applies accumulate and divide-by-zero rules.
- Holds the result stable while the pipeline is stalled downstream.
- Raises `ok` to the hazard unit; execute stalls while `req_valid && !ok`.

Parameters:
- MUL_LATENCY, 3, cycles from `mul_start` until `mul_prod` is valid (≥1).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  execute holds a valid instruction
- op  in  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MADD, 6 MADDU, 7 MSUB, 8 MSUBU, 9 MUL, 10 MTHI, 11 MTLO; 12-15 treated as NONE
- a, b  in  32  forwarded operands (rs, rt)
- hi_in, lo_in  in  32  current HI/LO, used by accumulate ops
- flush  in  1  kill the in-flight op
- stall_in  in  1  execute cannot advance this cycle (downstream stall)
- mul_start  out  1  one-cycle pulse
- mul_signed  out  1  signed multiply
- mul_prod  in  64  product
- div_start  out  1  one-cycle pulse
- div_signed  out  1  signed divide
- div_abort  out  1  one-cycle pulse
- div_done  in  1  quotient/remainder valid (level)
- div_q, div_r  in  32  quotient, remainder
- ok  out  1  result valid / no stall needed
- hi_we, lo_we  out  1  HI/LO write enables accompanying the result
- res_hi, res_lo  out  32  HI/LO result
- gpr_res  out  32  MUL GPR result (product[31:0])
- busy  out  1  state != IDLE

Behaviour:
- States:
  - IDLE.
  - MUL_WAIT: counter runs 0..MUL_LATENCY-1.
  - DIV_WAIT.
  - DONE.
- Reset:
  - state IDLE, counter 0.
  - res_hi/res_lo/gpr_res 0, hi_we/lo_we 0.
  - All start/abort pulses 0; ok forced 0 while reset is high.
- `ok` = (state==DONE) || (state==IDLE && (!req_valid || op is NONE)).
- `hi_we`/`lo_we` are driven only in DONE; otherwise 0.
- IDLE, req_valid, !flush:
  - Ops 1,2,5-9: `mul_start`=1; `mul_signed`=1 for 1,5,7,9; go to MUL_WAIT.
  - Ops 3,4:
    - b≠0: `div_start`=1; `div_signed`=(op==3); go to DIV_WAIT.
    - b==0: latch res_hi=a, res_lo=32'hFFFF_FFFF; go to DONE.
  - MTHI: latch res_hi=a, hi_we=1 only; go to DONE.
  - MTLO: latch res_lo=a, lo_we=1 only; go to DONE.
- MUL_WAIT:
  - On counter==MUL_LATENCY-1, sample `mul_prod` and latch.
  - MULT(U): {hi,lo}=prod.
  - MADD(U): {hi,lo}={hi_in,lo_in}+prod.
  - MSUB(U): {hi,lo}={hi_in,lo_in}−prod.
  - Accumulate arithmetic is 64-bit modulo 2^64.
  - MUL: gpr_res=prod[31:0]; hi_we=lo_we=0.
  - Then go to DONE.
- DIV_WAIT: when div_done, latch res_lo=div_q, res_hi=div_r; go to DONE.
- Latencies (request accepted in cycle T):
  - mult-class: ok high at T+MUL_LATENCY+1.
  - divide: ok high the cycle after div_done.
  - MTHI/MTLO/div-by-zero: ok high at T+1.
- DONE:
  - Outputs held stable.
  - Leave to IDLE when !stall_in; remain in DONE while stall_in.
  - A new op can be accepted in IDLE the next cycle; the just-finished op is never restarted.
- flush (highest priority, any state):
  - Go to IDLE next cycle; no DONE reached.
  - `div_abort` pulses if state is DIV_WAIT, or if `div_start` would be issued this cycle.
  - `mul_start` and `div_start` are suppressed in a flush cycle.
  - A late `mul_prod`/`div_done` after a flush is ignored.
- Reset mid-operation behaves like flush, except `div_abort` is not pulsed; the divider is reset by the same reset.
- hi_in/lo_in are sampled at latch time, not at request time.

Test Plan:
- MULT, a=0xFFFF_FFFE, b=3, MUL_LATENCY=3, req at T0 → mul_start at T0 (signed); ok=0 at T1-T3; ok=1 at T4; res_hi=0xFFFF_FFFF, res_lo=0xFFFF_FFFA; hi_we=lo_we=1.
- MADDU, hi_in=0, lo_in=0xFFFF_FFFF, a=1, b=1 → res_hi=1, res_lo=0.
- MSUB, hi_in=lo_in=0, a=1, b=1 → {res_hi,res_lo}=0xFFFF_FFFF_FFFF_FFFF.
- DIVU, a=100, b=7, divider asserts div_done at T0+33 → ok at T0+34; res_lo=14, res_hi=2.
- DIV, a=5, b=0 → no div_start; ok at T+1; res_hi=5, res_lo=0xFFFF_FFFF.
- Flush in DIV_WAIT:
  - div_abort pulses once; IDLE next cycle; ok=0; a late div_done is ignored.
  - A following MTLO, a=0x1234, gives ok at T+1, lo_we=1, hi_we=0, res_lo=0x1234.
- MUL with stall_in held 4 cycles after ok:
  - ok and gpr_res stay stable and no second mul_start is issued.
  - IDLE the cycle after stall_in drops.
